// File: rtl/cordic_range_reduce.sv
// Range-reduction front end for the CORDIC core: wraps/folds rotation angles into
// [-pi/2, pi/2] and folds vectoring inputs into the right half-plane.
module cordic_range_reduce #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] Xi,
  input  logic [N-1:0] Yi,
  input  logic [N-1:0] Zi,
  input  logic         rot_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Xo,
  output logic [N-1:0] Yo,
  output logic [N-1:0] Zo,
  output logic         rot_vec_o,
  output logic         flip
);

  // Q4.28 constants
  localparam logic signed [N-1:0] Pi2   = 32'sh1921FB54;
  localparam logic signed [N-1:0] Pi    = 32'sh3243F6A9;
  localparam logic signed [N-1:0] TwoPi = 32'sh6487ED51;
  localparam logic signed [N-1:0] MinV  = {1'b1, {(N-1){1'b0}}};
  localparam logic signed [N-1:0] MaxV  = {1'b0, {(N-1){1'b1}}};

  typedef enum logic [1:0] {StIdle, StWrap, StOut} state_e;

  state_e                state_q, state_d;
  logic signed [N-1:0]   x_q, x_d;
  logic signed [N-1:0]   y_q, y_d;
  logic signed [N-1:0]   z_q, z_d;
  logic                  rv_q, rv_d;
  logic                  flip_q, flip_d;

  // The most negative value has no positive twin; clamp instead of wrapping.
  function automatic logic signed [N-1:0] sat_neg(input logic signed [N-1:0] v);
    if (v == MinV) return MaxV;
    return -v;
  endfunction

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    rv_d    = rv_q;
    flip_d  = flip_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          x_d     = Xi;
          y_d     = Yi;
          z_d     = Zi;
          rv_d    = rot_vec;
          flip_d  = 1'b0;
          state_d = StWrap;
        end
      end
      StWrap: begin
        if (rv_q) begin
          if (z_q > Pi) begin
            z_d = z_q - TwoPi;
          end else if (z_q < -Pi) begin
            z_d = z_q + TwoPi;
          end else begin
            state_d = StOut;
            if (z_q > Pi2) begin
              z_d    = z_q - Pi;
              x_d    = sat_neg(x_q);
              y_d    = sat_neg(y_q);
              flip_d = 1'b1;
            end else if (z_q < -Pi2) begin
              z_d    = z_q + Pi;
              x_d    = sat_neg(x_q);
              y_d    = sat_neg(y_q);
              flip_d = 1'b1;
            end else begin
              flip_d = 1'b0;
            end
          end
        end else begin
          state_d = StOut;
          if (x_q[N-1]) begin
            x_d    = sat_neg(x_q);
            y_d    = sat_neg(y_q);
            z_d    = y_q[N-1] ? z_q - Pi : z_q + Pi;
            flip_d = 1'b1;
          end else begin
            flip_d = 1'b0;
          end
        end
      end
      StOut: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      rv_q    <= 1'b0;
      flip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      rv_q    <= rv_d;
      flip_q  <= flip_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StOut);
  assign Xo        = x_q;
  assign Yo        = y_q;
  assign Zo        = z_q;
  assign rot_vec_o = rv_q;
  assign flip      = flip_q;

endmodule
